dram_initiator: RTL and testbench
=================================

# dram_initiator

Requester-side sequencer for the 128-bit-line DRAM port (MIG controller or its simulation model). It accepts single-word read/write requests from the core over a valid/ready handshake and issues one-cycle `rd_en`/`wr_en` pulses with an active-low byte mask. It waits out `busy`, selects the addressed word from the returned 4-word line, and returns a one-cycle response. It sits between the memory arbiter and the DRAM port.

## Interface
- `TIMEOUT_CYC`, 1024: maximum cycles spent in SETTLE+WAIT before the access is abandoned.
- `w_CLK` in 1: the single clock; every register samples on its rising edge.
- `w_RST` in 1: asynchronous, active-high reset.
- `w_i_req_valid` in 1: core request valid.
- `w_o_req_ready` out 1: request accepted when valid & ready.
- `w_i_req_we` in 1: 1 = write, 0 = read.
- `w_i_req_addr` in 32: byte address.
- `w_i_req_wdata` in 32: write data.
- `w_i_req_be` in 4: active-high byte enables for writes.
- `w_o_rsp_valid` out 1: one-cycle completion pulse for reads and writes; no backpressure.
- `w_o_rsp_rdata` out 32: read word, valid with `rsp_valid`; 0 for writes.
- `w_o_err` out 1: sticky timeout flag.
- `w_i_dram_rst_n` in 1: DRAM port ready; no request accepted while low.
- `w_o_rd_en`, `w_o_wr_en` out 1: one-cycle DRAM command pulses.
- `w_o_addr` out 32: `{addr[31:2],2'b00}`.
- `w_o_data` out 32: write data.
- `w_o_mask` out 4: `~be`. 0 means full-word write.
- `w_i_data3..w_i_data0` in 32 each: returned line. `data0` is word 0.
- `w_i_busy` in 1: DRAM busy.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, WAIT, RESP.
- IDLE:
  - `req_ready = w_i_dram_rst_n`.
  - On accept, register we/addr/wdata/be and go to ISSUE.
  - Exception: a write with be==0 goes directly to RESP with no DRAM command.
- ISSUE:
  - Drive `rd_en` (read) or `wr_en` (write) high for exactly this cycle.
  - Go to SETTLE.
- SETTLE: `busy` is ignored for one cycle; go to WAIT.
- WAIT:
  - When `busy==0`, capture the word selected by `addr[3:2]` (0→data0 … 3→data3) for reads, then go to RESP.
  - Otherwise stay in WAIT.
- RESP: `rsp_valid=1` for one cycle; go to IDLE.
- Timeout:
  - A counter clears on ISSUE and increments in SETTLE and WAIT.
  - When it reaches `TIMEOUT_CYC`, set `err` and return `rdata=32'hDEAD_BEEF` via RESP. Writes also get RESP, with `rdata=0`.
  - `err` clears only on reset.
- `rd_en` and `wr_en` are never high together, and never high outside ISSUE.

## Timing
- Reset values: every output 0, state IDLE, `err=0`.
  - `req_ready` is 0 during reset and becomes `w_i_dram_rst_n` once reset releases.
- Reset mid-operation: the FSM returns to IDLE asynchronously, command pulses drop immediately, and the in-flight request is discarded with no response.
- Read against the 1-cycle-busy model, accepted at cycle T:
  - `rd_en` high at T+1.
  - `busy` high at T+2.
  - Line captured at the end of T+3.
  - `rsp_valid` at T+4.
  - `req_ready` again at T+5.
- Writes take the same latency.
- A longer `busy` extends WAIT one cycle per busy cycle.
- `w_i_dram_rst_n` falling mid-transaction does not abort it. Only the IDLE accept is gated.

## Configuration
- `DRAM_LINE_BUF_EN` defined: adds a one-line read buffer (128-bit data, tag `addr[31:4]`, valid bit).
  - Read hit in IDLE: go directly to RESP, so `rsp_valid` at T+1 with no DRAM command.
  - Read miss: fill the buffer on WAIT capture.
  - Writes are write-through. On a tag match, enabled bytes are merged into the buffer in the same cycle as ISSUE.
  - The buffer is invalidated on reset and on timeout.
- Macro not defined: no buffer; every read goes to DRAM.

## Structure
- Package `dram_pkg`:
  - FSM state enum.
  - `DRAM_ERR_WORD=32'hDEAD_BEEF`.
  - `LINE_WORDS=4`, `LINE_OFF_W=4`.
- Sub-module `dram_line_buf` (tag compare, byte-merge, fill), instantiated only under `DRAM_LINE_BUF_EN`.

## Test plan
- Write `addr=0x100`, `wdata=0xA5A5_1234`, `be=4'hF`, then read `0x100`:
  - `wr_en` pulse with `mask=0`.
  - Read returns `0xA5A5_1234` with `rsp_valid` at T+4.
- Partial write `be=4'b0010`, `wdata=0x0000_7700` over `0x1111_1111`: `mask=4'b1101`, and the read returns `0x1111_7711`.
- Reads of `0x200/0x204/0x208/0x20C`: each selects `data0/1/2/3` respectively.
- Hold `busy=1` forever:
  - `err` rises after `TIMEOUT_CYC`.
  - The read responds with `0xDEAD_BEEF`.
  - The next request is still accepted.
- Assert `w_RST` during WAIT: `rd_en=0` and `rsp_valid=0` immediately, and no stale response appears after release.
- With `DRAM_LINE_BUF_EN`:
  - A second read of `0x104` after a read of `0x100` responds at T+1 with no `rd_en`.
  - A write to `0x108` followed by a read of `0x108` returns the new data.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM requester: FSM states, line geometry,
// the word returned on an abandoned read, and the line word-select helper.
package dram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } dram_state_t;

  localparam logic [31:0] DRAM_ERR_WORD = 32'hDEAD_BEEF;
  localparam int          LINE_WORDS    = 4;
  localparam int          LINE_OFF_W    = 4;

  // Word 0 sits in the low 32 bits of the line.
  function automatic logic [31:0] sel_word(input logic [LINE_WORDS*32-1:0] line,
                                           input logic [1:0]               idx);
    return line[{idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/dram_line_buf.sv
// One-line read buffer for dram_initiator: tag compare, byte merge of
// write-through data on a tag match, and fill from a completed read.
module dram_line_buf
  import dram_pkg::*;
(
  input  logic                         w_CLK,
  input  logic                         w_RST,
  input  logic [31:LINE_OFF_W]         lookup_tag,
  input  logic [1:0]                   lookup_word,
  output logic                         hit,
  output logic [31:0]                  hit_word,
  input  logic                         fill_en,
  input  logic [31:LINE_OFF_W]         fill_tag,
  input  logic [LINE_WORDS*32-1:0]     fill_line,
  input  logic                         merge_en,
  input  logic [31:LINE_OFF_W]         merge_tag,
  input  logic [1:0]                   merge_word,
  input  logic [31:0]                  merge_data,
  input  logic [3:0]                   merge_be,
  input  logic                         inval
);

  logic [LINE_WORDS*32-1:0] line_q;
  logic [31:LINE_OFF_W]     tag_q;
  logic                     valid_q;

  assign hit      = valid_q && (tag_q == lookup_tag);
  assign hit_word = sel_word(line_q, lookup_word);

  always_ff @(posedge w_CLK or posedge w_RST) begin
    if (w_RST) begin
      line_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (inval) begin
      valid_q <= 1'b0;
    end else if (fill_en) begin
      line_q  <= fill_line;
      tag_q   <= fill_tag;
      valid_q <= 1'b1;
    end else if (merge_en && valid_q && (tag_q == merge_tag)) begin
      for (int b = 0; b < 4; b++) begin
        if (merge_be[b]) line_q[{merge_word, 2'(b), 3'b000} +: 8] <= merge_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dram_initiator.sv
// Core-side sequencer for the 128-bit-line DRAM port: one request in flight,
// command pulse, busy wait with timeout, one-cycle response.
// Define DRAM_LINE_BUF_EN to add a one-line read buffer (dram_line_buf).
module dram_initiator
  import dram_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        w_CLK,
  input  logic        w_RST,
  input  logic        w_i_req_valid,
  output logic        w_o_req_ready,
  input  logic        w_i_req_we,
  input  logic [31:0] w_i_req_addr,
  input  logic [31:0] w_i_req_wdata,
  input  logic [3:0]  w_i_req_be,
  output logic        w_o_rsp_valid,
  output logic [31:0] w_o_rsp_rdata,
  output logic        w_o_err,
  input  logic        w_i_dram_rst_n,
  output logic        w_o_rd_en,
  output logic        w_o_wr_en,
  output logic [31:0] w_o_addr,
  output logic [31:0] w_o_data,
  output logic [3:0]  w_o_mask,
  input  logic [31:0] w_i_data3,
  input  logic [31:0] w_i_data2,
  input  logic [31:0] w_i_data1,
  input  logic [31:0] w_i_data0,
  input  logic        w_i_busy,
  output dram_state_t w_o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  dram_state_t              state_q, state_d;
  logic                     we_q;
  logic [31:2]              addr_q;
  logic [31:0]              wdata_q, rdata_q;
  logic [3:0]               mask_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     err_q;
  logic                     accept, capture, timeout;
  logic                     buf_hit;
  logic [31:0]              buf_word;
  logic [LINE_WORDS*32-1:0] line;
  logic                     unused_addr_lsb;

  assign line            = {w_i_data3, w_i_data2, w_i_data1, w_i_data0};
  assign unused_addr_lsb = ^w_i_req_addr[1:0];

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; ready is only offered in IDLE with the port up and reset released.
  // The response is a single-cycle rsp_valid pulse with no backpressure.
  assign accept = w_i_req_valid && w_o_req_ready;

  always_ff @(posedge w_CLK or posedge w_RST) begin
    if (w_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    w_o_req_ready = 1'b0;
    w_o_rd_en     = 1'b0;
    w_o_wr_en     = 1'b0;
    capture       = 1'b0;
    timeout       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        w_o_req_ready = w_i_dram_rst_n && !w_RST;
        if (w_i_req_valid && w_o_req_ready) begin
          if (w_i_req_we && (w_i_req_be == 4'h0)) state_d = ST_RESP;
          else if (!w_i_req_we && buf_hit)        state_d = ST_RESP;
          else                                    state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_o_rd_en = !we_q;
        w_o_wr_en = we_q;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!w_i_busy) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge w_CLK or posedge w_RST) begin
    if (w_RST) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= w_i_req_we;
        addr_q  <= w_i_req_addr[31:2];
        wdata_q <= w_i_req_wdata;
        mask_q  <= ~w_i_req_be;
        rdata_q <= (!w_i_req_we && buf_hit) ? buf_word : 32'h0;
      end
      if (state_q == ST_ISSUE) cnt_q <= '0;
      else if (state_q == ST_SETTLE || state_q == ST_WAIT) cnt_q <= cnt_q + 1'b1;
      if (capture && !we_q) rdata_q <= sel_word(line, addr_q[3:2]);
      if (timeout) begin
        err_q <= 1'b1;
        if (!we_q) rdata_q <= DRAM_ERR_WORD;
      end
    end
  end

`ifdef DRAM_LINE_BUF_EN
  dram_line_buf u_line_buf (
    .w_CLK      (w_CLK),
    .w_RST      (w_RST),
    .lookup_tag (w_i_req_addr[31:LINE_OFF_W]),
    .lookup_word(w_i_req_addr[3:2]),
    .hit        (buf_hit),
    .hit_word   (buf_word),
    .fill_en    (capture && !we_q),
    .fill_tag   (addr_q[31:LINE_OFF_W]),
    .fill_line  (line),
    .merge_en   ((state_q == ST_ISSUE) && we_q),
    .merge_tag  (addr_q[31:LINE_OFF_W]),
    .merge_word (addr_q[3:2]),
    .merge_data (wdata_q),
    .merge_be   (~mask_q),
    .inval      (timeout)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_word = 32'h0;
`endif

  assign w_o_rsp_valid = (state_q == ST_RESP);
  assign w_o_rsp_rdata = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign w_o_err       = err_q;
  assign w_o_addr      = {addr_q, 2'b00};
  assign w_o_data      = wdata_q;
  assign w_o_mask      = mask_q;
  assign w_o_dbg_state = state_q;

endmodule

// File: tb/tb_dram_initiator.sv
// Directed bench for dram_initiator with a small DRAM port model (memory plus
// configurable busy length); each scenario task checks its own results.
module tb_dram_initiator;
  import dram_pkg::*;

  logic        w_CLK = 1'b0;
  logic        w_RST = 1'b1;
  logic        w_i_req_valid = 1'b0;
  logic        w_o_req_ready;
  logic        w_i_req_we = 1'b0;
  logic [31:0] w_i_req_addr = '0;
  logic [31:0] w_i_req_wdata = '0;
  logic [3:0]  w_i_req_be = '0;
  logic        w_o_rsp_valid;
  logic [31:0] w_o_rsp_rdata;
  logic        w_o_err;
  logic        w_i_dram_rst_n = 1'b1;
  logic        w_o_rd_en, w_o_wr_en;
  logic [31:0] w_o_addr, w_o_data;
  logic [3:0]  w_o_mask;
  logic [31:0] w_i_data3, w_i_data2, w_i_data1, w_i_data0;
  logic        w_i_busy;
  dram_state_t dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  dram_initiator #(.TIMEOUT_CYC(1024)) dut (
    .w_CLK(w_CLK), .w_RST(w_RST),
    .w_i_req_valid(w_i_req_valid), .w_o_req_ready(w_o_req_ready),
    .w_i_req_we(w_i_req_we), .w_i_req_addr(w_i_req_addr),
    .w_i_req_wdata(w_i_req_wdata), .w_i_req_be(w_i_req_be),
    .w_o_rsp_valid(w_o_rsp_valid), .w_o_rsp_rdata(w_o_rsp_rdata),
    .w_o_err(w_o_err), .w_i_dram_rst_n(w_i_dram_rst_n),
    .w_o_rd_en(w_o_rd_en), .w_o_wr_en(w_o_wr_en),
    .w_o_addr(w_o_addr), .w_o_data(w_o_data), .w_o_mask(w_o_mask),
    .w_i_data3(w_i_data3), .w_i_data2(w_i_data2),
    .w_i_data1(w_i_data1), .w_i_data0(w_i_data0),
    .w_i_busy(w_i_busy), .w_o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 w_CLK = ~w_CLK;

  // DRAM port model: busy rises the cycle after a command for busy_len cycles.
  logic [31:0] mem [0:1023];
  logic [7:0]  last_line = '0;
  int          busy_rem = 0;
  int          busy_len = 1;
  bit          hold_busy = 1'b0;

  always @(posedge w_CLK) begin
    if (w_o_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (!w_o_mask[b]) mem[w_o_addr[11:2]][b*8 +: 8] <= w_o_data[b*8 +: 8];
    end
    if (w_o_rd_en || w_o_wr_en) begin
      last_line <= w_o_addr[11:4];
      busy_rem  <= busy_len;
    end else if (busy_rem > 0) begin
      busy_rem <= busy_rem - 1;
    end
  end

  assign w_i_busy  = hold_busy || (busy_rem != 0);
  assign w_i_data0 = mem[{last_line, 2'd0}];
  assign w_i_data1 = mem[{last_line, 2'd1}];
  assign w_i_data2 = mem[{last_line, 2'd2}];
  assign w_i_data3 = mem[{last_line, 2'd3}];

  // driver: lat counts cycles from accept (T) to rsp_valid; -1 when no response arrives
  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output int lat, output logic [31:0] rdata,
                           output int rd_cnt, output int wr_cnt, output logic [31:0] cmd_addr,
                           output logic [31:0] cmd_data, output logic [3:0] cmd_mask);
    int guard;
    lat = -1; rdata = '0; rd_cnt = 0; wr_cnt = 0;
    cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    @(negedge w_CLK);
    w_i_req_valid = 1'b1; w_i_req_we = we; w_i_req_addr = addr;
    w_i_req_wdata = wdata; w_i_req_be = be;
    guard = 0;
    while (w_o_req_ready !== 1'b1 && guard < 50) begin
      @(negedge w_CLK);
      guard++;
    end
    if (w_o_req_ready !== 1'b1) begin
      w_i_req_valid = 1'b0;
      return;
    end
    @(negedge w_CLK);
    w_i_req_valid = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      if (w_o_rd_en === 1'b1) rd_cnt++;
      if (w_o_wr_en === 1'b1) wr_cnt++;
      if (w_o_rd_en === 1'b1 || w_o_wr_en === 1'b1) begin
        cmd_addr = w_o_addr; cmd_data = w_o_data; cmd_mask = w_o_mask;
      end
      if (w_o_rsp_valid === 1'b1) begin
        lat = k;
        rdata = w_o_rsp_rdata;
        break;
      end
      @(negedge w_CLK);
    end
  endtask

  int lat, rd_cnt, wr_cnt;
  logic [31:0] rdata, cmd_addr, cmd_data;
  logic [3:0] cmd_mask;

  task automatic test_reset();
    repeat (2) @(negedge w_CLK);
    tests_run++; if (w_o_req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", w_o_req_ready); end
    tests_run++; if ({w_o_rsp_valid, w_o_rd_en, w_o_wr_en, w_o_err} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", {w_o_rsp_valid, w_o_rd_en, w_o_wr_en, w_o_err}); end
    tests_run++; if ({w_o_addr, w_o_data, w_o_mask, w_o_rsp_rdata} !== 100'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", {w_o_addr, w_o_data, w_o_mask, w_o_rsp_rdata}); end
    tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    w_RST = 1'b0;
    #1;
    tests_run++; if (w_o_req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b want 1", w_o_req_ready); end
  endtask

  task automatic test_full_write_read();
    drive_req(1'b1, 32'h100, 32'hA5A5_1234, 4'hF, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (wr_cnt !== 1 || rd_cnt !== 0) begin tests_failed++; $display("FAIL wr_pulse: got wr=%0d rd=%0d want 1/0", wr_cnt, rd_cnt); end
    tests_run++; if ({cmd_addr, cmd_data, cmd_mask} !== {32'h100, 32'hA5A5_1234, 4'h0}) begin tests_failed++; $display("FAIL wr_cmd: got %h/%h/%h want 100/a5a51234/0", cmd_addr, cmd_data, cmd_mask); end
    tests_run++; if (lat !== 4 || rdata !== 32'h0) begin tests_failed++; $display("FAIL wr_rsp: got lat=%0d rdata=%h want 4/0", lat, rdata); end
    @(negedge w_CLK);
    tests_run++; if (w_o_req_ready !== 1'b1 || w_o_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL wr_t5: got ready=%b rsp=%b want 1/0", w_o_req_ready, w_o_rsp_valid); end
    drive_req(1'b0, 32'h100, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (rd_cnt !== 1 || wr_cnt !== 0) begin tests_failed++; $display("FAIL rd_pulse: got rd=%0d wr=%0d want 1/0", rd_cnt, wr_cnt); end
    tests_run++; if (lat !== 4 || rdata !== 32'hA5A5_1234) begin tests_failed++; $display("FAIL rd_full: got lat=%0d rdata=%h want 4/a5a51234", lat, rdata); end
  endtask

  task automatic test_zero_be_write();
    drive_req(1'b1, 32'h100, 32'hFFFF_FFFF, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (lat !== 1 || wr_cnt !== 0 || rd_cnt !== 0 || rdata !== 32'h0) begin tests_failed++; $display("FAIL zero_be: got lat=%0d wr=%0d rd=%0d rdata=%h want 1/0/0/0", lat, wr_cnt, rd_cnt, rdata); end
    drive_req(1'b0, 32'h100, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (rdata !== 32'hA5A5_1234) begin tests_failed++; $display("FAIL zero_be_keep: got %h want a5a51234", rdata); end
  endtask

  task automatic test_partial_write();
    drive_req(1'b1, 32'h300, 32'h1111_1111, 4'hF, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    drive_req(1'b1, 32'h300, 32'h0000_7700, 4'b0010, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (cmd_mask !== 4'b1101 || wr_cnt !== 1) begin tests_failed++; $display("FAIL part_mask: got %b wr=%0d want 1101/1", cmd_mask, wr_cnt); end
    drive_req(1'b0, 32'h300, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (rdata !== 32'h1111_7711) begin tests_failed++; $display("FAIL part_read: got %h want 11117711", rdata); end
  endtask

  task automatic test_word_select();
    logic [31:0] vals [4];
    vals[0] = 32'hD000_0200; vals[1] = 32'hD111_0204; vals[2] = 32'hD222_0208; vals[3] = 32'hD333_020C;
    for (int i = 0; i < 4; i++)
      drive_req(1'b1, 32'h200 + 32'(i * 4), vals[i], 4'hF, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 32'h200 + 32'(i * 4), 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
      tests_run++; if (rdata !== vals[i]) begin tests_failed++; $display("FAIL word_sel%0d: got %h want %h", i, rdata, vals[i]); end
    end
    drive_req(1'b0, 32'h20E, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (rdata !== 32'hD333_020C) begin tests_failed++; $display("FAIL word_sel_unaligned: got %h want d333020c", rdata); end
  endtask

  task automatic test_long_busy();
    busy_len = 3;
    drive_req(1'b1, 32'h400, 32'h4444_0400, 4'hF, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (lat !== 6) begin tests_failed++; $display("FAIL long_busy_wr: got lat=%0d want 6", lat); end
    drive_req(1'b0, 32'h404, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    drive_req(1'b0, 32'h400, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    busy_len = 1;
  endtask

  task automatic test_long_busy_read();
    busy_len = 3;
    drive_req(1'b1, 32'h440, 32'h4444_0440, 4'hF, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    drive_req(1'b0, 32'h440, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (lat !== 6 || rdata !== 32'h4444_0440) begin tests_failed++; $display("FAIL long_busy_rd: got lat=%0d rdata=%h want 6/44440440", lat, rdata); end
    busy_len = 1;
  endtask

  task automatic test_dram_rst_n();
    int rd_seen, rsp_at;
    logic [31:0] got;
    drive_req(1'b1, 32'h800, 32'hCAFE_0800, 4'hF, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    @(negedge w_CLK);
    w_i_dram_rst_n = 1'b0;
    w_i_req_valid = 1'b1; w_i_req_we = 1'b0; w_i_req_addr = 32'h800;
    #1;
    tests_run++; if (w_o_req_ready !== 1'b0) begin tests_failed++; $display("FAIL port_down_ready: got %b want 0", w_o_req_ready); end
    rd_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge w_CLK);
      if (w_o_rd_en === 1'b1 || w_o_rsp_valid === 1'b1) rd_seen++;
    end
    tests_run++; if (rd_seen !== 0) begin tests_failed++; $display("FAIL port_down_gate: got %0d events want 0", rd_seen); end
    w_i_dram_rst_n = 1'b1;
    #1;
    tests_run++; if (w_o_req_ready !== 1'b1) begin tests_failed++; $display("FAIL port_up_ready: got %b want 1", w_o_req_ready); end
    @(negedge w_CLK);
    w_i_req_valid = 1'b0;
    tests_run++; if (w_o_rd_en !== 1'b1) begin tests_failed++; $display("FAIL port_up_rd_en: got %b want 1", w_o_rd_en); end
    @(negedge w_CLK);
    w_i_dram_rst_n = 1'b0;
    rsp_at = -1; got = '0;
    for (int k = 3; k < 12; k++) begin
      @(negedge w_CLK);
      if (w_o_rsp_valid === 1'b1 && rsp_at < 0) begin rsp_at = k; got = w_o_rsp_rdata; end
    end
    tests_run++; if (rsp_at !== 4 || got !== 32'hCAFE_0800) begin tests_failed++; $display("FAIL port_drop_midflight: got cyc=%0d rdata=%h want 4/cafe0800", rsp_at, got); end
    w_i_dram_rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    hold_busy = 1'b1;
    drive_req(1'b0, 32'h500, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (lat < 1024 || lat > 1030) begin tests_failed++; $display("FAIL timeout_lat: got %0d want 1024..1030", lat); end
    tests_run++; if (rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL timeout_rdata: got %h want deadbeef", rdata); end
    tests_run++; if (w_o_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_err: got %b want 1", w_o_err); end
    hold_busy = 1'b0;
    drive_req(1'b1, 32'h600, 32'h0600_0600, 4'hF, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (lat !== 4 || wr_cnt !== 1) begin tests_failed++; $display("FAIL after_timeout: got lat=%0d wr=%0d want 4/1", lat, wr_cnt); end
    tests_run++; if (w_o_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b want 1", w_o_err); end
  endtask

  task automatic test_reset_mid();
    int stale;
    busy_len = 6;
    @(negedge w_CLK);
    w_i_req_valid = 1'b1; w_i_req_we = 1'b0; w_i_req_addr = 32'h700;
    #1;
    tests_run++; if (w_o_req_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_ready: got %b want 1", w_o_req_ready); end
    @(negedge w_CLK);
    w_i_req_valid = 1'b0;
    repeat (2) @(negedge w_CLK);
    tests_run++; if (dbg_state !== ST_WAIT) begin tests_failed++; $display("FAIL mid_in_wait: got %0d want 3", dbg_state); end
    w_RST = 1'b1;
    #1;
    tests_run++; if ({w_o_rd_en, w_o_rsp_valid, w_o_req_ready, w_o_err} !== 4'b0) begin tests_failed++; $display("FAIL mid_reset_outs: got %b want 0000", {w_o_rd_en, w_o_rsp_valid, w_o_req_ready, w_o_err}); end
    @(negedge w_CLK);
    w_RST = 1'b0;
    busy_len = 1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge w_CLK);
      if (w_o_rsp_valid === 1'b1 || w_o_rd_en === 1'b1) stale++;
    end
    tests_run++; if (stale !== 0) begin tests_failed++; $display("FAIL mid_stale: got %0d events want 0", stale); end
  endtask

`ifdef DRAM_LINE_BUF_EN
  task automatic test_line_buf();
    drive_req(1'b1, 32'h104, 32'h0104_0104, 4'hF, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    drive_req(1'b0, 32'h100, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (lat !== 4 || rdata !== 32'hA5A5_1234) begin tests_failed++; $display("FAIL buf_miss: got lat=%0d rdata=%h want 4/a5a51234", lat, rdata); end
    drive_req(1'b0, 32'h104, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (lat !== 1 || rd_cnt !== 0 || rdata !== 32'h0104_0104) begin tests_failed++; $display("FAIL buf_hit: got lat=%0d rd=%0d rdata=%h want 1/0/01040104", lat, rd_cnt, rdata); end
    drive_req(1'b1, 32'h108, 32'hBEEF_0108, 4'hF, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    drive_req(1'b0, 32'h108, 32'h0, 4'h0, lat, rdata, rd_cnt, wr_cnt, cmd_addr, cmd_data, cmd_mask);
    tests_run++; if (lat !== 1 || rdata !== 32'hBEEF_0108) begin tests_failed++; $display("FAIL buf_merge: got lat=%0d rdata=%h want 1/beef0108", lat, rdata); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_write_read();
    test_zero_be_write();
    test_partial_write();
    test_word_select();
    test_long_busy();
    test_long_busy_read();
    test_dram_rst_n();
    test_timeout();
    test_reset_mid();
`ifdef DRAM_LINE_BUF_EN
    test_line_buf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // rd_en and wr_en must never be seen together
  always @(negedge w_CLK) begin
    if (w_o_rd_en === 1'b1 && w_o_wr_en === 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL cmd_exclusive: got rd=1 wr=1 want at most one");
    end
  end

endmodule
